traffic_phase_ctrl: RTL and testbench

//   Two-way traffic-light phase sequencer for the DE-board traffic experiment.

---
 rtl/traffic_phase_ctrl_pkg.sv | 25 ++
 rtl/traffic_phase_ctrl_if.sv | 24 ++
 rtl/traffic_phase_ctrl_sec_tick_gen.sv | 27 ++
 rtl/traffic_phase_ctrl.sv | 111 +++++++++++
 tb/tb_traffic_phase_ctrl.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/traffic_phase_ctrl_pkg.sv
// rtl/traffic_phase_ctrl_pkg.sv - phase codes, light encodings and default timings
package traffic_phase_ctrl_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5
  } phase_e;

  // Light vectors are {red,yellow,green}
  localparam logic [2:0] LIGHT_R = 3'b100;
  localparam logic [2:0] LIGHT_Y = 3'b010;
  localparam logic [2:0] LIGHT_G = 3'b001;

  localparam int TICK_DIV_DEF  = 16_000_000;
  localparam int GREEN_DEF_S   = 20;
  localparam int GREEN_MIN_S   = 5;
  localparam int GREEN_MAX_S   = 60;
  localparam int YELLOW_S      = 3;
  localparam int ALLRED_S      = 1;

endpackage

// File: rtl/traffic_phase_ctrl_if.sv
// rtl/traffic_phase_ctrl_if.sv - operator inputs and light/display outputs of the phase sequencer
interface traffic_phase_ctrl_if;

  logic       pause;
  logic       btn_up;
  logic       btn_dn;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic [2:0] phase;
  logic       tick;

  modport master (
    output pause, btn_up, btn_dn,
    input  ns_light, ew_light, sec_tens, sec_ones, phase, tick
  );

  modport slave (
    input  pause, btn_up, btn_dn,
    output ns_light, ew_light, sec_tens, sec_ones, phase, tick
  );

endinterface

// File: rtl/traffic_phase_ctrl_sec_tick_gen.sv
// rtl/traffic_phase_ctrl_sec_tick_gen.sv - clk prescaler producing a one-cycle seconds strobe
module traffic_phase_ctrl_sec_tick_gen #(
  parameter int TICK_DIV = 16_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic hold,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  // hold parks the count so a resumed second finishes its remaining cycles
  assign tick = (count == LAST) && !hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!hold) begin
      count <= (count == LAST) ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// rtl/traffic_phase_ctrl.sv - six-phase two-way traffic light sequencer with BCD countdown
module traffic_phase_ctrl
  import traffic_phase_ctrl_pkg::*;
#(
  parameter int TICK_DIV  = TICK_DIV_DEF,
  parameter int GREEN_DEF = GREEN_DEF_S,
  parameter int GREEN_MIN = GREEN_MIN_S,
  parameter int GREEN_MAX = GREEN_MAX_S,
  parameter int YELLOW_T  = YELLOW_S,
  parameter int ALLRED_T  = ALLRED_S
) (
  input logic                 clk,
  input logic                 rst,
  traffic_phase_ctrl_if.slave bus
);

  logic [1:0] pause_sync;
  logic [2:0] up_sh;
  logic [2:0] dn_sh;
  logic       pause_s;
  logic       up_press;
  logic       dn_press;
  logic       tick;
  logic [6:0] green_len;
  phase_e     phase_q, phase_d, nxt;
  logic [6:0] remain_q, remain_d, nxt_len;
  logic [2:0] ns_l, ew_l;
  logic       illegal;

  // Buttons idle high; shift[1] is the synchronised level, shift[2] its previous value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pause_sync <= 2'b00;
      up_sh      <= 3'b111;
      dn_sh      <= 3'b111;
    end else begin
      pause_sync <= {pause_sync[0], bus.pause};
      up_sh      <= {up_sh[1:0], bus.btn_up};
      dn_sh      <= {dn_sh[1:0], bus.btn_dn};
    end
  end

  assign pause_s  = pause_sync[1];
  assign up_press = up_sh[2] & ~up_sh[1];
  assign dn_press = dn_sh[2] & ~dn_sh[1];

  traffic_phase_ctrl_sec_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .hold (pause_s),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      green_len <= 7'(GREEN_DEF);
    end else if (up_press && !dn_press && green_len < 7'(GREEN_MAX)) begin
      green_len <= green_len + 7'd1;
    end else if (dn_press && !up_press && green_len > 7'(GREEN_MIN)) begin
      green_len <= green_len - 7'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= NS_GREEN;
      remain_q <= 7'(GREEN_DEF);
    end else begin
      phase_q  <= phase_d;
      remain_q <= remain_d;
    end
  end

  always_comb begin
    phase_d  = phase_q;
    remain_d = remain_q;
    nxt      = NS_GREEN;
    nxt_len  = green_len;
    ns_l     = LIGHT_R;
    ew_l     = LIGHT_R;
    illegal  = 1'b0;
    case (phase_q)
      NS_GREEN:  begin nxt = NS_YELLOW; nxt_len = 7'(YELLOW_T); ns_l = LIGHT_G; end
      NS_YELLOW: begin nxt = ALLRED_A;  nxt_len = 7'(ALLRED_T); ns_l = LIGHT_Y; end
      ALLRED_A:  begin nxt = EW_GREEN;  nxt_len = green_len;                   end
      EW_GREEN:  begin nxt = EW_YELLOW; nxt_len = 7'(YELLOW_T); ew_l = LIGHT_G; end
      EW_YELLOW: begin nxt = ALLRED_B;  nxt_len = 7'(ALLRED_T); ew_l = LIGHT_Y; end
      ALLRED_B:  begin nxt = NS_GREEN;  nxt_len = green_len;                   end
      default:   illegal = 1'b1;
    endcase
    if (illegal) begin
      phase_d  = NS_GREEN;
      remain_d = green_len;
    end else if (tick) begin
      if (remain_q == 7'd1) begin
        phase_d  = nxt;
        remain_d = nxt_len;
      end else begin
        remain_d = remain_q - 7'd1;
      end
    end
  end

  assign bus.ns_light = ns_l;
  assign bus.ew_light = ew_l;
  assign bus.phase    = phase_q;
  assign bus.tick     = tick;
  assign bus.sec_tens = 4'(remain_q / 7'd10);
  assign bus.sec_ones = 4'(remain_q % 7'd10);

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb/tb_traffic_phase_ctrl.sv - directed vector bench for traffic_phase_ctrl
module tb_traffic_phase_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  traffic_phase_ctrl_if bus();

  traffic_phase_ctrl #(.TICK_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int e;
    int ph;
    int ns;
    int ew;
    int tens;
    int ones;
    int tk;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int ph, input int ns, input int ew,
                           input int tens, input int ones);
    chk({tag, " phase"}, int'(bus.phase), ph);
    chk({tag, " ns"}, int'(bus.ns_light), ns);
    chk({tag, " ew"}, int'(bus.ew_light), ew);
    chk({tag, " tens"}, int'(bus.sec_tens), tens);
    chk({tag, " ones"}, int'(bus.sec_ones), ones);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.pause  = 1'b0;
    bus.btn_up = 1'b1;
    bus.btn_dn = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic press(input bit up, input bit dn);
    bus.btn_up = !up;
    bus.btn_dn = !dn;
    repeat (3) @(negedge clk);
    bus.btn_up = 1'b1;
    bus.btn_dn = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_green(input string name, input int tens, input int ones);
    logic [2:0] prev;
    bit hit;
    hit  = 1'b0;
    prev = bus.phase;
    for (int i = 0; i < 3000 && !hit; i++) begin
      step(1);
      if (bus.phase != prev && (bus.phase == 3'd0 || bus.phase == 3'd3)) hit = 1'b1;
      prev = bus.phase;
    end
    chk({name, " reached"}, int'(hit), 1);
    if (hit) begin
      chk({name, " tens"}, int'(bus.sec_tens), tens);
      chk({name, " ones"}, int'(bus.sec_ones), ones);
    end
  endtask

  initial begin
    int e_now;

    vecs[0]  = '{0,   0, 'b001, 'b100, 2, 0, 0};
    vecs[1]  = '{3,   0, 'b001, 'b100, 2, 0, 1};
    vecs[2]  = '{4,   0, 'b001, 'b100, 1, 9, 0};
    vecs[3]  = '{79,  0, 'b001, 'b100, 0, 1, 1};
    vecs[4]  = '{80,  1, 'b010, 'b100, 0, 3, 0};
    vecs[5]  = '{91,  1, 'b010, 'b100, 0, 1, 1};
    vecs[6]  = '{92,  2, 'b100, 'b100, 0, 1, 0};
    vecs[7]  = '{95,  2, 'b100, 'b100, 0, 1, 1};
    vecs[8]  = '{96,  3, 'b100, 'b001, 2, 0, 0};
    vecs[9]  = '{175, 3, 'b100, 'b001, 0, 1, 1};
    vecs[10] = '{176, 4, 'b100, 'b010, 0, 3, 0};
    vecs[11] = '{188, 5, 'b100, 'b100, 0, 1, 0};
    vecs[12] = '{191, 5, 'b100, 'b100, 0, 1, 1};
    vecs[13] = '{192, 0, 'b001, 'b100, 2, 0, 0};

    bus.pause  = 1'b0;
    bus.btn_up = 1'b1;
    bus.btn_dn = 1'b1;
    @(negedge clk);
    chk_state("reset", 0, 'b001, 'b100, 2, 0);
    chk("reset tick", int'(bus.tick), 0);

    // Free-running full cycle against absolute clock-edge checkpoints
    do_reset();
    e_now = 0;
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].e > e_now) step(vecs[i].e - e_now);
      e_now = vecs[i].e;
      chk_state($sformatf("v%0d", i), vecs[i].ph, vecs[i].ns, vecs[i].ew,
                vecs[i].tens, vecs[i].ones);
      chk($sformatf("v%0d tick", i), int'(bus.tick), vecs[i].tk);
    end

    // Pause at display 12, then resume
    do_reset();
    step(33);
    chk_state("pre_pause", 0, 'b001, 'b100, 1, 2);
    bus.pause = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step(1);
      chk("pause tick", int'(bus.tick), 0);
      chk_state("pause", 0, 'b001, 'b100, 1, 2);
    end
    bus.pause = 1'b0;
    step(2);
    chk("resume tick", int'(bus.tick), 1);
    chk_state("resume", 0, 'b001, 'b100, 1, 2);
    step(1);
    chk_state("resume_dec", 0, 'b001, 'b100, 1, 1);

    // Up presses leave the running green alone and apply at next green entry
    do_reset();
    repeat (3) press(1'b1, 1'b0);
    step(22);
    chk_state("up_e40", 0, 'b001, 'b100, 1, 0);
    step(40);
    chk_state("up_e80", 1, 'b010, 'b100, 0, 3);
    step(16);
    chk_state("up_e96", 3, 'b100, 'b001, 2, 3);
    repeat (45) press(1'b1, 1'b0);
    wait_green("sat_max", 6, 0);
    repeat (70) press(1'b0, 1'b1);
    wait_green("sat_min", 0, 5);

    // Simultaneous up/dn cancels; a long hold counts once
    do_reset();
    press(1'b1, 1'b1);
    bus.btn_up = 1'b0;
    repeat (50) @(negedge clk);
    bus.btn_up = 1'b1;
    repeat (3) @(negedge clk);
    wait_green("both_hold", 2, 1);

    // Asynchronous reset between clock edges during EW_YELLOW
    do_reset();
    step(180);
    chk_state("ew_yellow", 4, 'b100, 'b010, 0, 2);
    #2;
    rst = 1'b1;
    #1;
    chk_state("async_rst", 0, 'b001, 'b100, 2, 0);
    chk("async_rst tick", int'(bus.tick), 0);
    @(negedge clk);
    rst = 1'b0;
    step(4);
    chk_state("post_rst", 0, 'b001, 'b100, 1, 9);

    // Illegal phase code recovers to NS_GREEN with a fresh green count
    step(6);
    chk_state("pre_force", 0, 'b001, 'b100, 1, 8);
    force dut.phase_q = traffic_phase_ctrl_pkg::phase_e'(3'd7);
    #1;
    chk("forced phase", int'(bus.phase), 7);
    release dut.phase_q;
    step(1);
    chk_state("illegal_recover", 0, 'b001, 'b100, 2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
